// File: rtl/wb_commit_unit.sv
// wb_commit_unit
// Writeback stage that feeds the RV32E register-file write port.
// Completed instructions arrive from execute over a valid/ready handshake.
// Non-loads commit one cycle after accept. Loads wait for memory read data,
// which is sign- or zero-extended by funct3 and byte offset, and then commit.
// Every retired instruction, including a faulted one, gives exactly one
// commit_valid pulse.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   handshake from the execute unit
//   in_rd                 destination register (only [3:0] is architectural)
//   in_result             ALU/CSR/link result (ignored for loads)
//   in_is_load            instruction is a load
//   in_funct3             load type
//   in_addr_lo            load byte address [1:0]
//   mem_rvalid            one-cycle read-data pulse from memory
//   mem_rdata             aligned read word
//   mem_rerr              bus error, qualified by mem_rvalid
//   rf_wen/rf_waddr/rf_wdata  register-file write port
//   commit_valid          one pulse per retired instruction
//   commit_err            qualifies commit_valid: faulted, no write performed
//   pend_valid/pend_rd    outstanding load and its destination (hazard stall)
module wb_commit_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rerr,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit_valid,
  output logic                  commit_err,
  output logic                  pend_valid,
  output logic [ADDR_WIDTH-1:0] pend_rd
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  commit_valid_q, commit_valid_d;
  logic                  commit_err_q, commit_err_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0] pend_rd_q, pend_rd_d;
  logic [2:0]            ld_funct3_q, ld_funct3_d;
  logic [1:0]            ld_off_q, ld_off_d;

  logic accept;
  logic rd_out_of_range;
  logic ld_fault;
  logic in_fault;

  // Select the addressed byte/halfword of the aligned word and extend it.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [2:0]            f3,
    input logic [1:0]            off,
    input logic [DATA_WIDTH-1:0] word
  );
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extend = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  load_extend = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b010:  load_extend = word;
      3'b100:  load_extend = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  load_extend = {{(DATA_WIDTH-16){1'b0}}, h};
      default: load_extend = '0;
    endcase
  endfunction

  assign in_ready = (state_q != WAIT_MEM);
  assign accept   = in_valid & in_ready;

  // Destinations x16..x31 do not exist in RV32E.
  assign rd_out_of_range = |in_rd[ADDR_WIDTH-1:4];

  always_comb begin
    case (in_funct3)
      3'b000, 3'b100: ld_fault = 1'b0;
      3'b001, 3'b101: ld_fault = in_addr_lo[0];
      3'b010:         ld_fault = (in_addr_lo != 2'b00);
      default:        ld_fault = 1'b1;
    endcase
  end

  // A faulting load never reaches memory; it retires like a non-load.
  assign in_fault = rd_out_of_range | (in_is_load & ld_fault);

  always_comb begin
    state_d        = state_q;
    rf_wen_d       = 1'b0;
    commit_valid_d = 1'b0;
    commit_err_d   = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    pend_valid_d   = pend_valid_q;
    pend_rd_d      = pend_rd_q;
    ld_funct3_d    = ld_funct3_q;
    ld_off_d       = ld_off_q;

    case (state_q)
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d        = COMMIT;
          pend_valid_d   = 1'b0;
          commit_valid_d = 1'b1;
          commit_err_d   = mem_rerr;
          rf_waddr_d     = pend_rd_q;
          rf_wen_d       = ~mem_rerr & (pend_rd_q[3:0] != 4'd0);
          if (!mem_rerr) begin
            rf_wdata_d = load_extend(ld_funct3_q, ld_off_q, mem_rdata);
          end
        end
      end
      default: begin
        // IDLE and COMMIT both accept; mem_rvalid is ignored here.
        if (accept) begin
          if (in_is_load && !in_fault) begin
            state_d      = WAIT_MEM;
            pend_valid_d = 1'b1;
            pend_rd_d    = in_rd;
            ld_funct3_d  = in_funct3;
            ld_off_d     = in_addr_lo;
          end else begin
            state_d        = COMMIT;
            commit_valid_d = 1'b1;
            commit_err_d   = in_fault;
            rf_waddr_d     = in_rd;
            rf_wen_d       = ~in_fault & (in_rd[3:0] != 4'd0);
            if (!in_fault) begin
              rf_wdata_d = in_result;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rf_wen_q       <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      commit_valid_q <= 1'b0;
      commit_err_q   <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_rd_q      <= '0;
      ld_funct3_q    <= 3'b000;
      ld_off_q       <= 2'b00;
    end else begin
      state_q        <= state_d;
      rf_wen_q       <= rf_wen_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_err_q   <= commit_err_d;
      pend_valid_q   <= pend_valid_d;
      pend_rd_q      <= pend_rd_d;
      ld_funct3_q    <= ld_funct3_d;
      ld_off_q       <= ld_off_d;
    end
  end

  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign commit_valid = commit_valid_q;
  assign commit_err   = commit_err_q;
  assign pend_valid   = pend_valid_q;
  assign pend_rd      = pend_rd_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
module tb_wb_commit_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rerr;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_valid;
  logic        commit_err;
  logic        pend_valid;
  logic [4:0]  pend_rd;

  int n_applied;
  int n_miss;

  wb_commit_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_result(in_result), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .commit_err(commit_err),
    .pend_valid(pend_valid), .pend_rd(pend_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] result;
    logic        is_load;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic        exp_wen;
    logic        exp_err;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_rd      = 5'd0;
    in_result  = 32'h0;
    in_is_load = 1'b0;
    in_funct3  = 3'b000;
    in_addr_lo = 2'b00;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    mem_rerr   = 1'b0;
  endtask

  // Issue a load, wait wcycles with memory silent, then return data.
  task automatic do_load(input string name, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] off, input int wcycles, input logic [31:0] rdata,
                         input logic rerr, input logic exp_wen, input logic exp_err,
                         input logic [31:0] exp_wdata);
    in_valid = 1'b1; in_rd = rd; in_is_load = 1'b1; in_funct3 = f3; in_addr_lo = off;
    in_result = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    // Scramble the in_* fields; the latched copies must be used.
    in_valid = 1'b0; in_funct3 = 3'b010; in_addr_lo = ~off; in_rd = 5'd3;
    for (int i = 0; i < wcycles; i++) begin
      chk({name, " wait in_ready"}, 32'(in_ready), 32'd0);
      chk({name, " wait pend_valid"}, 32'(pend_valid), 32'd1);
      chk({name, " wait pend_rd"}, 32'(pend_rd), 32'(rd));
      chk({name, " wait commit_valid"}, 32'(commit_valid), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    mem_rvalid = 1'b1; mem_rdata = rdata; mem_rerr = rerr;
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0; mem_rerr = 1'b0;
    chk({name, " commit_valid"}, 32'(commit_valid), 32'd1);
    chk({name, " commit_err"}, 32'(commit_err), 32'(exp_err));
    chk({name, " rf_wen"}, 32'(rf_wen), 32'(exp_wen));
    chk({name, " pend_valid"}, 32'(pend_valid), 32'd0);
    if (exp_wen) begin
      chk({name, " rf_waddr"}, 32'(rf_waddr), 32'(rd));
      chk({name, " rf_wdata"}, rf_wdata, exp_wdata);
    end
    @(posedge clk); @(negedge clk);
    chk({name, " after commit_valid"}, 32'(commit_valid), 32'd0);
    chk({name, " after rf_wen"}, 32'(rf_wen), 32'd0);
  endtask

  initial begin
    n_applied = 0;
    n_miss    = 0;
    idle_inputs();
    rst_n = 1'b0;

    vecs[0] = '{5'd5,  32'h1234_5678, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, 32'h1234_5678};
    vecs[1] = '{5'd0,  32'hCAFE_F00D, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{5'd9,  32'h0,         1'b1, 3'b001, 2'd1, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{5'd4,  32'h0,         1'b1, 3'b010, 2'd2, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{5'd6,  32'h0,         1'b1, 3'b011, 2'd0, 1'b0, 1'b1, 32'h0};
    vecs[5] = '{5'd16, 32'h5555_AAAA, 1'b0, 3'b000, 2'd0, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{5'd11, 32'h0,         1'b1, 3'b101, 2'd3, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{5'd15, 32'hFFFF_0001, 1'b0, 3'b111, 2'd3, 1'b1, 1'b0, 32'hFFFF_0001};

    // Reset state
    #1;
    chk("rst rf_wen", 32'(rf_wen), 32'd0);
    chk("rst rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst rf_wdata", rf_wdata, 32'd0);
    chk("rst commit_valid", 32'(commit_valid), 32'd0);
    chk("rst commit_err", 32'(commit_err), 32'd0);
    chk("rst pend_valid", 32'(pend_valid), 32'd0);
    chk("rst pend_rd", 32'(pend_rd), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-instruction table
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_rd = vecs[i].rd; in_result = vecs[i].result;
      in_is_load = vecs[i].is_load; in_funct3 = vecs[i].f3; in_addr_lo = vecs[i].off;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      idle_inputs();
      chk($sformatf("vec%0d commit_valid", i), 32'(commit_valid), 32'd1);
      chk($sformatf("vec%0d commit_err", i), 32'(commit_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d rf_wen", i), 32'(rf_wen), 32'(vecs[i].exp_wen));
      chk($sformatf("vec%0d pend_valid", i), 32'(pend_valid), 32'd0);
      if (!vecs[i].exp_err)
        chk($sformatf("vec%0d rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].rd));
      if (vecs[i].exp_wen)
        chk($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].exp_wdata);
      @(posedge clk); @(negedge clk);
      chk($sformatf("vec%0d next commit_valid", i), 32'(commit_valid), 32'd0);
      chk($sformatf("vec%0d next rf_wen", i), 32'(rf_wen), 32'd0);
      if (vecs[i].exp_wen)
        chk($sformatf("vec%0d hold rf_wdata", i), rf_wdata, vecs[i].exp_wdata);
    end

    // Back-to-back non-loads rd=1,2,3
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'(i); in_result = 32'h1000 + 32'(i);
      @(posedge clk); @(negedge clk);
      chk($sformatf("b2b%0d in_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("b2b%0d commit_valid", i), 32'(commit_valid), 32'd1);
      chk($sformatf("b2b%0d rf_wen", i), 32'(rf_wen), 32'd1);
      chk($sformatf("b2b%0d rf_waddr", i), 32'(rf_waddr), 32'(i));
      chk($sformatf("b2b%0d rf_wdata", i), rf_wdata, 32'h1000 + 32'(i));
    end
    idle_inputs();
    @(posedge clk); @(negedge clk);
    chk("b2b end commit_valid", 32'(commit_valid), 32'd0);

    // Loads from word 0x80AABBCC
    do_load("lb3",  5'd7, 3'b000, 2'd3, 4, 32'h80AA_BBCC, 1'b0, 1'b1, 1'b0, 32'hFFFF_FF80);
    do_load("lbu3", 5'd7, 3'b100, 2'd3, 4, 32'h80AA_BBCC, 1'b0, 1'b1, 1'b0, 32'h0000_0080);
    do_load("lh2",  5'd8, 3'b001, 2'd2, 1, 32'h80AA_BBCC, 1'b0, 1'b1, 1'b0, 32'hFFFF_80AA);
    do_load("lhu0", 5'd9, 3'b101, 2'd0, 2, 32'h80AA_BBCC, 1'b0, 1'b1, 1'b0, 32'h0000_BBCC);
    do_load("lw0",  5'd10, 3'b010, 2'd0, 0, 32'h80AA_BBCC, 1'b0, 1'b1, 1'b0, 32'h80AA_BBCC);
    do_load("lbu1", 5'd12, 3'b100, 2'd1, 1, 32'h80AA_BBCC, 1'b0, 1'b1, 1'b0, 32'h0000_00BB);
    do_load("lerr", 5'd13, 3'b010, 2'd0, 2, 32'h1111_2222, 1'b1, 1'b0, 1'b1, 32'h0);
    chk("lerr keeps rf_wdata", rf_wdata, 32'h0000_00BB);
    do_load("lrd0", 5'd0, 3'b000, 2'd0, 1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 32'h0);

    // Stray mem_rvalid while idle
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stray idle commit_valid", 32'(commit_valid), 32'd0);
    chk("stray idle rf_wen", 32'(rf_wen), 32'd0);
    chk("stray idle in_ready", 32'(in_ready), 32'd1);

    // Reset during WAIT_MEM, then a stray response
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd7; in_funct3 = 3'b010; in_addr_lo = 2'd0;
    @(posedge clk); @(negedge clk);
    idle_inputs();
    chk("rstmid pend_valid before", 32'(pend_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid async pend_valid", 32'(pend_valid), 32'd0);
    chk("rstmid async rf_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_ABCD;
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rstmid rf_wen", 32'(rf_wen), 32'd0);
    chk("rstmid commit_valid", 32'(commit_valid), 32'd0);
    chk("rstmid commit_err", 32'(commit_err), 32'd0);
    chk("rstmid rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rstmid rf_wdata", rf_wdata, 32'd0);
    chk("rstmid pend_valid", 32'(pend_valid), 32'd0);
    chk("rstmid pend_rd", 32'(pend_rd), 32'd0);
    chk("rstmid in_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
